// File: rtl/reg_seq_pkg.sv
// Shared opcode, FSM-state and instruction-field definitions for the
// register-file operation sequencer.
package reg_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RA_MSB = 7;
  localparam int RA_LSB = 4;
  localparam int RB_MSB = 3;
  localparam int RB_LSB = 0;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_SHR);
  endfunction

  function automatic logic op_sets_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/reg_op_sequencer_alu.sv
// Combinational ALU for the sequencer: result, carry/borrow and whether the
// opcode produces a register write.
module seq_alu
  import reg_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_out_o,
  output logic              writes_o
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // The extra MSB of the widened difference is the borrow (A < B).
  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s = {1'b0, a_i} - {1'b0, b_i};

  // Opcode decode
  always_comb begin
    result_o    = '0;
    carry_out_o = 1'b0;
    writes_o    = 1'b1;
    case (opcode_i)
      OP_NOP: writes_o = 1'b0;
      OP_ADD: begin
        result_o    = sum_s[DATA_W-1:0];
        carry_out_o = sum_s[DATA_W];
      end
      OP_SUB: begin
        result_o    = diff_s[DATA_W-1:0];
        carry_out_o = diff_s[DATA_W];
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_MOV: result_o = a_i;
      OP_LDI: result_o = imm_i;
      OP_SHL: result_o = {a_i[DATA_W-2:0], 1'b0};
      OP_SHR: result_o = {1'b0, a_i[DATA_W-1:1]};
      default: writes_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Four-state sequencer: accepts one instruction, reads register_file,
// computes through seq_alu and issues at most one write-back per instruction.
module reg_op_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] A_sel,
  output logic [ADDR_W-1:0] B_sel,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [ADDR_W-1:0] replaceSel,
  output logic [DATA_W-1:0] replaceData,
  output logic              replaceEn,
  output logic              done,
  output logic              zero,
  output logic              carry,
  output logic              illegal
);

  logic [1:0]        state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] a_sel_q, a_sel_d, b_sel_q, b_sel_d;
  logic [ADDR_W-1:0] rsel_q, rsel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ren_q, ren_d, done_q, done_d;
  logic              zero_q, zero_d, carry_q, carry_d, illegal_q, illegal_d;

  logic [3:0]        op_s;
  logic [DATA_W-1:0] alu_result_s;
  logic              alu_carry_s;
  logic              alu_writes_s;

  assign op_s = instr_q[OP_MSB:OP_LSB];

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode_i    (op_s),
    .a_i         (A),
    .b_i         (B),
    .imm_i       (DATA_W'(instr_q[RA_MSB:RB_LSB])),
    .result_o    (alu_result_s),
    .carry_out_o (alu_carry_s),
    .writes_o    (alu_writes_s)
  );

  // Next-state logic; EXEC results land in the write-back registers on the
  // EXEC->WRITE edge so they are presented during the WRITE cycle.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    a_sel_d   = a_sel_q;
    b_sel_d   = b_sel_q;
    rsel_d    = rsel_q;
    rdata_d   = rdata_q;
    ren_d     = 1'b0;
    done_d    = 1'b0;
    zero_d    = zero_q;
    carry_d   = carry_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && ready_q) begin
          instr_d = instr;
          a_sel_d = ADDR_W'(instr[RA_MSB:RA_LSB]);
          b_sel_d = ADDR_W'(instr[RB_MSB:RB_LSB]);
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d   = ST_WRITE;
        rsel_d    = ADDR_W'(instr_q[RD_MSB:RD_LSB]);
        rdata_d   = alu_result_s;
        ren_d     = alu_writes_s;
        done_d    = 1'b1;
        illegal_d = !op_is_legal(op_s);
        if (alu_writes_s) begin
          zero_d = (alu_result_s == '0);
        end else begin
          zero_d = zero_q;
        end
        if (op_sets_carry(op_s)) begin
          carry_d = alu_carry_s;
        end else begin
          carry_d = carry_q;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      instr_q   <= 16'h0000;
      ready_q   <= 1'b1;
      a_sel_q   <= '0;
      b_sel_q   <= '0;
      rsel_q    <= '0;
      rdata_q   <= '0;
      ren_q     <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      ready_q   <= ready_d;
      a_sel_q   <= a_sel_d;
      b_sel_q   <= b_sel_d;
      rsel_q    <= rsel_d;
      rdata_q   <= rdata_d;
      ren_q     <= ren_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_ready = ready_q;
  assign A_sel       = a_sel_q;
  assign B_sel       = b_sel_q;
  assign replaceSel  = rsel_q;
  assign replaceData = rdata_q;
  assign replaceEn   = ren_q;
  assign done        = done_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a behavioural register file on
// the A/B and replace ports.
module tb_reg_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  A_sel, B_sel, replaceSel;
  logic [7:0]  A, B, replaceData;
  logic        replaceEn, done, zero, carry, illegal;

  logic [7:0]  rf [16] = '{default: 8'h00};

  reg_op_sequencer #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .A_sel       (A_sel),
    .B_sel       (B_sel),
    .A           (A),
    .B           (B),
    .replaceSel  (replaceSel),
    .replaceData (replaceData),
    .replaceEn   (replaceEn),
    .done        (done),
    .zero        (zero),
    .carry       (carry),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign A = rf[A_sel];
  assign B = rf[B_sel];

  always @(posedge clk) begin
    if (replaceEn) rf[replaceSel] <= replaceData;
  end

  typedef struct {
    logic [15:0] ins;
    logic        en;
    logic [7:0]  data;
    logic        z;
    logic        c;
    logic        ill;
  } vec_t;

  vec_t vecs [16];
  int   n_vec = 0;
  int   n_miss = 0;

  logic [3:0] r_asel, r_bsel;
  logic [2:0] r_busy;
  logic [1:0] r_post;
  logic       w_en, w_done, w_z, w_c, w_ill;
  logic [3:0] w_sel;
  logic [7:0] w_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offer one instruction in IDLE and sample every phase until back in IDLE.
  task automatic issue(input logic [15:0] ins);
    int g = 0;
    @(negedge clk);
    while (!instr_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("issue_ready", 32'(instr_ready), 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    r_asel = A_sel;
    r_bsel = B_sel;
    r_busy = {instr_ready, replaceEn, done};
    @(negedge clk);
    r_busy |= {instr_ready, replaceEn, done};
    @(negedge clk);
    r_busy |= {instr_ready, 1'b0, 1'b0};
    w_en = replaceEn; w_done = done; w_sel = replaceSel; w_data = replaceData;
    w_z = zero; w_c = carry; w_ill = illegal;
    @(negedge clk);
    r_post = {replaceEn, done};
  endtask

  logic [15:0] bq [3];
  logic [7:0]  bd [3];
  int          lat;

  initial begin
    vecs[0]  = '{16'h70AA, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'h7156, 1'b1, 8'h56, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h1201, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{16'h2310, 1'b1, 8'hAC, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'h5400, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16'hF512, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{16'h6610, 1'b1, 8'h56, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{16'h3701, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{16'h4801, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{16'h8900, 1'b1, 8'h54, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{16'h9A00, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{16'h1B11, 1'b1, 8'hAC, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{16'h2C01, 1'b1, 8'h54, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{16'hA000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{16'h7D00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    bq[0] = 16'h7211; bq[1] = 16'h7322; bq[2] = 16'h1423;
    bd[0] = 8'h11;    bd[1] = 8'h22;    bd[2] = 8'h33;

    // Reset held with a valid instruction offered.
    instr = 16'h7F33;
    instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_outs", 32'({A_sel, B_sel, replaceSel, replaceData, replaceEn, done,
                         zero, carry, illegal}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_latency", 32'(lat), 32'd3);
    chk("rst_first_sel", 32'(replaceSel), 32'hF);
    chk("rst_first_data", 32'(replaceData), 32'h33);

    // Table-driven single instructions.
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = vecs[i];
      issue(v.ins);
      chk("A_sel", 32'(r_asel), 32'(v.ins[7:4]));
      chk("B_sel", 32'(r_bsel), 32'(v.ins[3:0]));
      chk("busy_quiet", 32'(r_busy), 32'd0);
      chk("replaceEn", 32'(w_en), 32'(v.en));
      chk("done", 32'(w_done), 32'd1);
      if (v.en) begin
        chk("replaceSel", 32'(w_sel), 32'(v.ins[11:8]));
        chk("replaceData", 32'(w_data), 32'(v.data));
      end
      chk("zero", 32'(w_z), 32'(v.z));
      chk("carry", 32'(w_c), 32'(v.c));
      chk("illegal", 32'(w_ill), 32'(v.ill));
      chk("pulse_end", 32'(r_post), 32'd0);
    end

    // Back-to-back with instr_valid held high; busy cycles offer a decoy.
    lat = 0;
    while (!instr_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    for (int k = 0; k < 12; k++) begin
      chk("b2b_ready", 32'(instr_ready), 32'(k % 4 == 0));
      chk("b2b_en", 32'(replaceEn), 32'(k % 4 == 3));
      if (k % 4 == 3) begin
        chk("b2b_sel", 32'(replaceSel), 32'(bq[k/4][11:8]));
        chk("b2b_data", 32'(replaceData), 32'(bd[k/4]));
      end
      instr_valid = 1'b1;
      instr = (k % 4 == 0) ? bq[k/4] : 16'h7EFF;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("b2b_decoy", 32'(rf[14]), 32'd0);
    chk("b2b_r4", 32'(rf[4]), 32'h33);

    // Reset during EXEC of ADD r5 = r2 + r3.
    @(negedge clk);
    instr = 16'h1523;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(instr_ready), 32'd1);
    chk("midrst_outs", 32'({A_sel, B_sel, replaceSel, replaceData, replaceEn, done,
                            zero, carry, illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (replaceEn || done) lat++;
    end
    chk("midrst_no_write", 32'(lat), 32'd0);
    chk("midrst_r5", 32'(rf[5]), 32'd0);
    issue(16'h7512);
    chk("ldi_r5_en", 32'(w_en), 32'd1);
    chk("ldi_r5_data", 32'(w_data), 32'h12);
    chk("ldi_r5_rf", 32'(rf[5]), 32'h12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
- Control stage directly upstream and downstream of register_file.
- Accepts one 16-bit register-to-register instruction over a valid/ready handshake.
- Drives register_file read selects (A_sel/B_sel), consumes its A/B outputs, computes an 8-bit ALU result, and writes it back through replaceData/replaceSel.
- Sequenced by a 4-state FSM, so register_file sees at most one write per instruction.

Parameters:
- DATA_W, 8, datapath width; matches register_file data width.
- ADDR_W, 4, register select width; 16 registers.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  16  {opcode[15:12], rd[11:8], ra[7:4], rb[3:0]}.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  sequencer can accept an instruction.
- A_sel  output  ADDR_W  to register_file A read select.
- B_sel  output  ADDR_W  to register_file B read select.
- A  input  DATA_W  from register_file, combinational read of A_sel.
- B  input  DATA_W  from register_file, combinational read of B_sel.
- replaceSel  output  ADDR_W  write-back register index.
- replaceData  output  DATA_W  write-back data.
- replaceEn  output  1  write strobe; register_file writes only when it is 1.
- done  output  1  one-cycle pulse at instruction retirement.
- zero  output  1  last retired result == 0.
- carry  output  1  carry-out from the last ADD, or borrow from the last SUB.
- illegal  output  1  last instruction had an undefined opcode.

Behaviour:
- Asynchronous reset sets:
  - state = IDLE; instr_ready = 1.
  - A_sel, B_sel, replaceSel, replaceData = 0.
  - replaceEn, done, zero, carry, illegal = 0.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE, one cycle each.
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr, go to READ.
  - READ: A_sel = ra, B_sel = rb; selects held stable through EXEC.
  - EXEC: sample A/B, compute the result into an internal register, set pending flags.
  - WRITE:
    - replaceSel = rd, replaceData = result.
    - replaceEn = 1 unless opcode is NOP or illegal.
    - done = 1; zero/carry/illegal update this cycle.
    - Next state IDLE.
- Throughput: one instruction per 4 cycles.
- Latency: accept edge to replaceEn/done = 3 cycles.
- instr_ready = 0 in READ, EXEC and WRITE; instr_valid is ignored there and the instruction is not captured.
- Opcodes (result is DATA_W bits, modulo 2^DATA_W):
  - 0 NOP: no write.
  - 1 ADD: A+B; carry = bit DATA_W of the sum.
  - 2 SUB: A-B; carry = 1 when A<B (borrow).
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 MOV: result = A.
  - 7 LDI: result = {ra, rb} as an 8-bit immediate; no register read needed.
  - 8 SHL: A<<1. 9 SHR: A>>1, logical.
  - 10-15: illegal = 1, no write.
- carry is updated only by ADD/SUB and holds otherwise.
- zero is updated by every writing opcode.
- illegal is cleared by the next legal retirement.
- replaceEn and done are high for exactly one cycle per instruction.
- replaceSel/replaceData hold their last values after WRITE.
- rd == ra or rd == rb: reads complete in EXEC before the write in WRITE, so old values are used.
- Reset asserted mid-instruction: the instruction is aborted, no write occurs, outputs return to reset values immediately.

Decomposition:
- Shared package reg_seq_pkg:
  - opcode localparams OP_NOP .. OP_SHR.
  - state encoding ST_IDLE, ST_READ, ST_EXEC, ST_WRITE.
  - instruction field bit positions.
- One natural sub-module: seq_alu, purely combinational. Inputs: opcode, A, B, imm. Outputs: result, carry_out, writes.
- The FSM, instruction latch and flag registers stay in reg_op_sequencer.

Test Plan:
- Reset behaviour: hold rst_n=0 with instr_valid=1 -> instr_ready=1, replaceEn=0, all outputs 0. Release reset -> the first accepted instruction retires exactly 3 cycles later.
- LDI r0 = 0xAA, then LDI r1 = 0x56, then ADD r2 = r0 + r1:
  - WRITE cycle: replaceSel=2, replaceData=0x00, replaceEn=1.
  - Flags: carry=1, zero=1, done pulse one cycle.
- SUB r3 = r1 - r0 (0x56 - 0xAA) -> replaceData=0xAC, carry=1, zero=0. Then XOR r4 = r0 ^ r0 -> replaceData=0x00, zero=1, carry unchanged (still 1).
- Back-to-back: instr_valid held high with 3 instructions queued -> accepted at cycles 0, 4 and 8; replaceEn asserted at cycles 3, 7 and 11 only; instructions offered in busy cycles are not captured.
- Illegal opcode 0xF, and NOP -> no replaceEn, done pulses. Illegal gives illegal=1; the following MOV clears it and writes A.
- Reset mid-operation: assert rst_n=0 during EXEC of ADD r5 -> no replaceEn for r5, state back to IDLE; a subsequent LDI r5 = 0x12 writes correctly.
